frame_send_ctrl: RTL and testbench



---
 rtl/frame_send_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_frame_send_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_send_ctrl.sv
// ---------------------------------------------------------------------------
// frame_send_ctrl
//
// Frame-transmit scheduler for the OV5640-to-Ethernet path. The block
// debounces the snapshot and mode keys and decides when the Ethernet frame
// sender may start a frame. A snapshot press requests one frame. The mode
// key toggles continuous mode, in which a frame is requested after every
// inter-frame gap. Each frame start is aligned to a rising edge of the camera
// VSYNC. frame_send_en stays high until the sender reports frame_over. The
// block then holds off for GAP_CYC cycles before it can start another frame.
//
// Optional feature, compile-time macro FRAME_TIMEOUT_EN:
//   defined   - a SEND that lasts TIMEOUT_CYC cycles without frame_over is
//               abandoned, and the sticky timeout_err flag is set.
//   undefined - SEND waits for frame_over indefinitely; timeout_err is 0.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   key_snap      in   snapshot key, high = pressed (asynchronous)
//   key_mode      in   mode key, high = pressed (asynchronous)
//   cam_vsync     in   camera VSYNC (asynchronous); a rising edge starts a frame
//   frame_over    in   one-cycle pulse: the current frame has been sent
//   frame_send_en out  frame send enable to the packetiser
//   cont_mode     out  1 = continuous mode
//   busy          out  high in any state other than IDLE
//   frame_cnt     out  completed frame count (wraps at 16'hFFFF)
//   timeout_err   out  sticky SEND timeout flag
// ---------------------------------------------------------------------------
module frame_send_ctrl #(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int GAP_CYC      = 1000,
    parameter int TIMEOUT_CYC  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_snap,
    input  logic        key_mode,
    input  logic        cam_vsync,
    input  logic        frame_over,
    output logic        frame_send_en,
    output logic        cont_mode,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DEB_FIRE = DW'(DEBOUNCE_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    // Input synchronisers. Bit 0 carries key_snap and bit 1 carries key_mode.
    logic [1:0] key_s1_q, key_s1_d;
    logic [1:0] key_s2_q, key_s2_d;
    // vs_sync_q[0] is sync1, [1] is sync2, and [2] is the edge-detect delay.
    logic [2:0] vs_sync_q, vs_sync_d;
    logic       vs_rise;

    logic [1:0] key_press;
    logic       snap_press;
    logic       mode_press;

    logic [1:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic          cont_mode_q, cont_mode_d;
    logic          send_en_q, send_en_d;
    logic          busy_q, busy_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          req;
    logic          pending_clr;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;
`endif

    // ------------------------------------------------------------------
    // Debounce, one counter per key. The counter saturates at DEBOUNCE_CYC,
    // so it passes DEBOUNCE_CYC-1 only once per hold. As a result, a held
    // key produces exactly one press pulse.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [DW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (!key_s2_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q != DEB_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign key_press[gi] = key_s2_q[gi] && (cnt_q == DEB_FIRE);
        end
    endgenerate

    assign snap_press = key_press[0];
    assign mode_press = key_press[1];
    assign vs_rise    = vs_sync_q[1] & ~vs_sync_q[2];
    assign req        = pending_q | cont_mode_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        key_s1_d    = {key_mode, key_snap};
        key_s2_d    = key_s1_q;
        vs_sync_d   = {vs_sync_q[1:0], cam_vsync};

        state_d     = state_q;
        send_en_d   = send_en_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        cont_mode_d = cont_mode_q ^ mode_press;
        pending_clr = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                // If continuous mode is dropped while no snapshot is pending,
                // nothing is left to wait for.
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    state_d     = ST_SEND;
                    send_en_d   = 1'b1;
                    pending_clr = 1'b1;
`ifdef FRAME_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            ST_SEND: begin
`ifdef FRAME_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                // frame_over takes priority over a timeout in the same cycle.
                if (frame_over) begin
                    state_d     = ST_GAP;
                    send_en_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = '0;
`ifdef FRAME_TIMEOUT_EN
                    tmo_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_GAP;
                    send_en_d   = 1'b0;
                    gap_cnt_d   = '0;
                    tmo_err_d   = 1'b1;
`endif
                end
            end
            default: begin // ST_GAP
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
        endcase

        // pending holds at most one request. A press that lands on the
        // same cycle the pending request is consumed is kept only if
        // nothing was pending before. A press that arrives while a
        // request is already pending is dropped.
        if (pending_clr) begin
            pending_d = snap_press & ~pending_q;
        end else begin
            pending_d = pending_q | snap_press;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            vs_sync_q   <= '0;
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            cont_mode_q <= 1'b0;
            send_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            vs_sync_q   <= vs_sync_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            cont_mode_q <= cont_mode_d;
            send_en_q   <= send_en_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign frame_send_en = send_en_q;
    assign cont_mode     = cont_mode_q;
    assign busy          = busy_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_frame_send_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_send_ctrl
//
// Directed testbench for frame_send_ctrl with DEBOUNCE_CYC=16, GAP_CYC=8 and
// TIMEOUT_CYC=100. Inputs change and outputs are sampled 1 ns after each
// rising clock edge.
// ---------------------------------------------------------------------------
module tb_frame_send_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_snap = 1'b0;
    logic        key_mode = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        frame_over = 1'b0;
    logic        frame_send_en;
    logic        cont_mode;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int compared = 0;
    int failed   = 0;

    frame_send_ctrl #(
        .DEBOUNCE_CYC (16),
        .GAP_CYC      (8),
        .TIMEOUT_CYC  (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_snap      (key_snap),
        .key_mode      (key_mode),
        .cam_vsync     (cam_vsync),
        .frame_over    (frame_over),
        .frame_send_en (frame_send_en),
        .cont_mode     (cont_mode),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise VSYNC and wait, with a bound, for frame_send_en to go high.
    // On return, the bench sits exactly on the edge where SEND started.
    task automatic vsync_start(input string tag);
        int n;
        n = 0;
        cam_vsync = 1'b1;
        while (frame_send_en !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        cam_vsync = 1'b0;
        check(tag, {31'd0, frame_send_en}, 32'd1);
    endtask

    task automatic press_snap();
        key_snap = 1'b1;
        step(30);
        key_snap = 1'b0;
        step(2);
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step(25);
        key_mode = 1'b0;
        step(2);
    endtask

    task automatic pulse_frame_over();
        frame_over = 1'b1;
        step(1);
        frame_over = 1'b0;
    endtask

    initial begin
        int n;

        // ---------------- reset ----------------
        step(3);
        check("rst_en",    {31'd0, frame_send_en}, 32'd0);
        check("rst_cont",  {31'd0, cont_mode},     32'd0);
        check("rst_busy",  {31'd0, busy},          32'd0);
        check("rst_cnt",   {16'd0, frame_cnt},     32'd0);
        check("rst_err",   {31'd0, timeout_err},   32'd0);
        rst_n = 1'b1;
        step(3);
        $display("txn: reset released");

        // ---------------- snapshot ----------------
        press_snap();
        check("snap_busy", {31'd0, busy},          32'd1);
        check("snap_noen", {31'd0, frame_send_en}, 32'd0);
        vsync_start("snap_en");
        step(50);
        check("snap_en_hold", {31'd0, frame_send_en}, 32'd1);
        pulse_frame_over();
        check("snap_en_off", {31'd0, frame_send_en}, 32'd0);
        check("snap_cnt",    {16'd0, frame_cnt},     32'd1);
        step(7);
        check("snap_gap_busy", {31'd0, busy}, 32'd1);
        step(1);
        check("snap_idle", {31'd0, busy}, 32'd0);
        step(5);
        check("snap_single", {31'd0, busy}, 32'd0);
        $display("txn: snapshot frame, frame_cnt=%0d", frame_cnt);

        // frame_over outside SEND is ignored
        pulse_frame_over();
        step(2);
        check("ovr_idle_cnt", {16'd0, frame_cnt}, 32'd1);

        // ---------------- bounce ----------------
        for (int i = 0; i < 5; i++) begin
            key_snap = 1'b1;
            step(10);
            key_snap = 1'b0;
            step(2);
        end
        step(25);
        check("bounce_idle", {31'd0, busy}, 32'd0);
        $display("txn: bounced key, busy=%0d", busy);

        // ---------------- continuous ----------------
        press_mode();
        check("cont_on",   {31'd0, cont_mode}, 32'd1);
        check("cont_busy", {31'd0, busy},      32'd1);
        for (int f = 1; f <= 3; f++) begin
            vsync_start("cont_en");
            step(5);
            if (f == 3) begin
                press_mode();
                check("cont_off", {31'd0, cont_mode}, 32'd0);
                check("cont_en_kept", {31'd0, frame_send_en}, 32'd1);
            end
            pulse_frame_over();
            check("cont_en_off", {31'd0, frame_send_en}, 32'd0);
            check("cont_cnt", {16'd0, frame_cnt}, 32'(1 + f));
            step(9);
            $display("txn: continuous frame %0d, frame_cnt=%0d", f, frame_cnt);
        end
        check("cont_end_idle", {31'd0, busy}, 32'd0);
        cam_vsync = 1'b1;
        step(4);
        cam_vsync = 1'b0;
        step(6);
        check("cont_no4th", {31'd0, frame_send_en}, 32'd0);
        check("cont_cnt_end", {16'd0, frame_cnt}, 32'd4);

`ifdef FRAME_TIMEOUT_EN
        // ---------------- timeout ----------------
        press_snap();
        vsync_start("tmo_en");
        n = 0;
        while (frame_send_en === 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check("tmo_len", 32'(n), 32'd100);
        check("tmo_err", {31'd0, timeout_err}, 32'd1);
        check("tmo_cnt", {16'd0, frame_cnt},   32'd4);
        step(9);
        check("tmo_idle", {31'd0, busy}, 32'd0);
        check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
        $display("txn: timeout frame, timeout_err=%0d", timeout_err);

        // ---------------- collision on the timeout cycle ----------------
        press_snap();
        vsync_start("col_en");
        step(99);
        check("col_en_hold", {31'd0, frame_send_en}, 32'd1);
        pulse_frame_over();
        check("col_cnt", {16'd0, frame_cnt},     32'd5);
        check("col_err", {31'd0, timeout_err},   32'd0);
        check("col_en",  {31'd0, frame_send_en}, 32'd0);
        step(9);
        $display("txn: collision frame, frame_cnt=%0d", frame_cnt);
`else
        // ---------------- no timeout logic ----------------
        press_snap();
        vsync_start("notmo_en");
        step(150);
        check("notmo_hold", {31'd0, frame_send_en}, 32'd1);
        check("notmo_err",  {31'd0, timeout_err},   32'd0);
        pulse_frame_over();
        check("notmo_cnt", {16'd0, frame_cnt}, 32'd5);
        step(9);
        $display("txn: long frame, frame_cnt=%0d", frame_cnt);
`endif

        // ---------------- reset mid-SEND ----------------
        press_mode();
        vsync_start("rst_mid_en");
        step(3);
        rst_n = 1'b0;
        #2;
        check("arst_en",   {31'd0, frame_send_en}, 32'd0);
        check("arst_busy", {31'd0, busy},          32'd0);
        check("arst_cont", {31'd0, cont_mode},     32'd0);
        check("arst_cnt",  {16'd0, frame_cnt},     32'd0);
        check("arst_err",  {31'd0, timeout_err},   32'd0);
        $display("txn: asynchronous reset during SEND");
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
